// File: rtl/adder_ring_pkg.sv
// adder_ring_pkg
//   Shared types and default sizing for the adder ring measurement block.
//   - state_t            : measurement FSM states
//   - DEF_COUNT_W        : default edge counter / result width
//   - DEF_WINDOW_W       : default measurement window length width
//   - DEF_SETTLE_CYCLES  : default ring settle time before counting (>= 1)
package adder_ring_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_COUNT_W       = 32;
  localparam int DEF_WINDOW_W      = 16;
  localparam int DEF_SETTLE_CYCLES = 4;

endpackage

// File: rtl/ring_edge_sync.sv
// ring_edge_sync
//   Brings the free-running ring oscillator tap into the clk domain and turns
//   its transitions into single-cycle pulses.
//   Optional feature macro: ADDER_RING_BOTH_EDGES_EN
//     undefined : pulse on rising ring edges only
//     defined   : pulse on both rising and falling ring edges
//   Ports:
//     clk        in   system clock
//     srst       in   synchronous active-high reset
//     ring_osc   in   asynchronous ring oscillator tap
//     edge_pulse out  registered one-cycle edge pulse (3 cycles after the pin)
module ring_edge_sync (
  input  logic clk,
  input  logic srst,
  input  logic ring_osc,
  output logic edge_pulse
);

  logic meta_reg;
  logic sync_reg;
  logic sync_d_reg;
  logic edge_reg;
  logic edge_next;

  // Only ring frequencies below clk/2 are resolved; faster rings alias.
`ifdef ADDER_RING_BOTH_EDGES_EN
  assign edge_next = sync_reg ^ sync_d_reg;
`else
  assign edge_next = sync_reg & ~sync_d_reg;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      sync_d_reg <= 1'b0;
      edge_reg   <= 1'b0;
    end else begin
      meta_reg   <= ring_osc;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
      edge_reg   <= edge_next;
    end
  end

  assign edge_pulse = edge_reg;

endmodule

// File: rtl/adder_ring_counter.sv
// adder_ring_counter
//   Measurement controller for the adder ring oscillator. A rising edge on
//   start_i enables the ring, lets it settle for SETTLE_CYCLES cycles, then
//   counts ring edges for window_i cycles and presents the saturating result.
//   Optional feature macro: ADDER_RING_BOTH_EDGES_EN (count both ring edges,
//   handled inside ring_edge_sync).
//   Ports:
//     wb_clk_i    in   system clock
//     wb_rst_i    in   synchronous active-high reset
//     start_i     in   start level; its rising edge starts a measurement
//     window_i    in   window length in cycles, latched at start
//     ring_osc_i  in   asynchronous ring oscillator tap
//     ring_en_o   out  ring oscillator enable
//     busy_o      out  measurement in progress
//     done_o      out  result valid, held until the next start
//     overflow_o  out  count saturated during the last measurement
//     count_o     out  edge count of the last measurement
module adder_ring_counter
  import adder_ring_pkg::*;
#(
  parameter int COUNT_W       = DEF_COUNT_W,
  parameter int WINDOW_W      = DEF_WINDOW_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic [WINDOW_W-1:0] window_i,
  input  logic                ring_osc_i,
  output logic                ring_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o,
  output logic [COUNT_W-1:0]  count_o
);

  // Settle counter holds 0 .. SETTLE_CYCLES-1; keep at least one bit.
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state_reg;
  logic                start_q_reg;
  logic [WINDOW_W-1:0] win_reg;
  logic [WINDOW_W-1:0] win_cnt_reg;
  logic [SETTLE_W-1:0] settle_cnt_reg;
  logic [COUNT_W-1:0]  count_reg;
  logic                overflow_reg;
  logic                ring_en_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                start_pulse;
  logic                ring_edge;

  ring_edge_sync u_edge (
    .clk        (wb_clk_i),
    .srst       (wb_rst_i),
    .ring_osc   (ring_osc_i),
    .edge_pulse (ring_edge)
  );

  assign start_pulse = start_i & ~start_q_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= IDLE;
      start_q_reg    <= 1'b0;
      win_reg        <= '0;
      win_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      ring_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      start_q_reg <= start_i;
      case (state_reg)
        // DONE restarts exactly like IDLE; the held result is cleared here.
        IDLE, DONE: begin
          if (start_pulse) begin
            win_reg        <= window_i;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            settle_cnt_reg <= SETTLE_LOAD;
            ring_en_reg    <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            state_reg      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == '0) begin
            if (win_reg == '0) begin
              ring_en_reg <= 1'b0;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= DONE;
            end else begin
              win_cnt_reg <= win_reg - 1'b1;
              state_reg   <= COUNT;
            end
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 1'b1;
          end
        end
        COUNT: begin
          // Saturate rather than wrap; an edge arriving at full scale is lost
          // and flagged.
          if (ring_edge) begin
            if (count_reg == '1) begin
              overflow_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
          if (win_cnt_reg == '0) begin
            ring_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end else begin
            win_cnt_reg <= win_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ring_en_o  = ring_en_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign overflow_o = overflow_reg;
  assign count_o    = count_reg;

endmodule

// File: tb/tb_adder_ring_counter.sv
// tb_adder_ring_counter
//   Directed bench for adder_ring_counter. A 32-bit instance runs every
//   scenario; a 4-bit instance shares the stimulus and is checked for
//   saturation. Expected counts scale by 2 when ADDER_RING_BOTH_EDGES_EN
//   is defined.
module tb_adder_ring_counter;

`ifdef ADDER_RING_BOTH_EDGES_EN
  localparam int EDGE_MUL = 2;
`else
  localparam int EDGE_MUL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ring = 1'b0;
  logic [15:0] window = '0;

  logic        ring_en, busy, done, overflow;
  logic [31:0] count;
  logic        n_ring_en, n_busy, n_done, n_overflow;
  logic [3:0]  n_count;

  int half = 3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_ring_counter #(.COUNT_W(32), .WINDOW_W(16), .SETTLE_CYCLES(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .window_i   (window),
    .ring_osc_i (ring),
    .ring_en_o  (ring_en),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (overflow),
    .count_o    (count)
  );

  adder_ring_counter #(.COUNT_W(4), .WINDOW_W(16), .SETTLE_CYCLES(4)) dut_narrow (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .window_i   (window),
    .ring_osc_i (ring),
    .ring_en_o  (n_ring_en),
    .busy_o     (n_busy),
    .done_o     (n_done),
    .overflow_o (n_overflow),
    .count_o    (n_count)
  );

  // Free-running ring: toggles every 'half' clocks, just after the edge.
  initial begin
    forever begin
      repeat (half) @(posedge clk);
      #1 ring = ~ring;
    end
  end

  // Raise start (after one low cycle) and watch until done_o, bounded.
  // Cycle n=1 is the sample just after the edge that sees the start pulse.
  task automatic run_measure(input logic [15:0] w, input int glitch_at,
                             output int busy_n, output int ren_n, output int done_at);
    busy_n = 0; ren_n = 0; done_at = 0;
    start = 1'b0;
    window = w;
    @(posedge clk); #1;
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == glitch_at) start = 1'b0;
      if (n == glitch_at + 1) start = 1'b1;
      if (busy) busy_n++;
      if (ring_en) ren_n++;
      if (done) begin
        done_at = n;
        break;
      end
    end
    $display("txn window=%0d done_at=%0d busy=%0d ring_en=%0d count=%0d ovf=%0b",
             w, done_at, busy_n, ren_n, count, overflow);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ring_en, busy, done, overflow, count} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b busy=%0b done=%0b ovf=%0b count=%0d, want all 0",
               ring_en, busy, done, overflow, count);
    end
    checks++;
    if ({n_ring_en, n_busy, n_done, n_overflow, n_count} !== 8'd0) begin
      errors++;
      $display("FAIL reset_narrow: got en=%0b busy=%0b done=%0b ovf=%0b count=%0d, want all 0",
               n_ring_en, n_busy, n_done, n_overflow, n_count);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic_count();
    int b, r, d;
    run_measure(16'd60, -5, b, r, d);
    checks++;
    if (d != 65) begin
      errors++;
      $display("FAIL basic_done_latency: got %0d, want 65", d);
    end
    checks++;
    if (b != 64 || r != 64) begin
      errors++;
      $display("FAIL basic_busy_cycles: got busy=%0d ring_en=%0d, want 64 64", b, r);
    end
    checks++;
    if (count !== 32'(10 * EDGE_MUL) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: got count=%0d ovf=%0b, want %0d 0", count, overflow, 10 * EDGE_MUL);
    end
    checks++;
    if (ring_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_outputs: got en=%0b busy=%0b, want 0 0", ring_en, busy);
    end
  endtask

  task automatic test_zero_window();
    int b, r, d;
    run_measure(16'd0, -5, b, r, d);
    checks++;
    if (d != 5) begin
      errors++;
      $display("FAIL zero_done_latency: got %0d, want 5", d);
    end
    checks++;
    if (r != 4) begin
      errors++;
      $display("FAIL zero_ring_en_cycles: got %0d, want 4", r);
    end
    checks++;
    if (count !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: got count=%0d ovf=%0b, want 0 0", count, overflow);
    end
  endtask

  task automatic test_saturation();
    int b, r, d;
    half = 1;
    repeat (8) @(posedge clk);
    run_measure(16'd100, -5, b, r, d);
    checks++;
    if (d != 105) begin
      errors++;
      $display("FAIL sat_done_latency: got %0d, want 105", d);
    end
    checks++;
    if (n_done !== 1'b1 || n_count !== 4'd15 || n_overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_narrow: got done=%0b count=%0d ovf=%0b, want 1 15 1",
               n_done, n_count, n_overflow);
    end
    checks++;
    if (count !== 32'(50 * EDGE_MUL) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide: got count=%0d ovf=%0b, want %0d 0", count, overflow, 50 * EDGE_MUL);
    end
    half = 3;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_restart_ignored();
    int b, r, d;
    run_measure(16'd60, 20, b, r, d);
    checks++;
    if (d != 65 || b != 64) begin
      errors++;
      $display("FAIL restart_timing: got done_at=%0d busy=%0d, want 65 64", d, b);
    end
    checks++;
    if (count !== 32'(10 * EDGE_MUL)) begin
      errors++;
      $display("FAIL restart_count: got %0d, want %0d", count, 10 * EDGE_MUL);
    end
  endtask

  task automatic test_reset_mid_count();
    int b, r, d;
    start = 1'b0;
    window = 16'd60;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    $display("txn reset_mid_count en=%0b busy=%0b done=%0b ovf=%0b count=%0d",
             ring_en, busy, done, overflow, count);
    checks++;
    if ({ring_en, busy, done, overflow, count} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid_count: got en=%0b busy=%0b done=%0b ovf=%0b count=%0d, want all 0",
               ring_en, busy, done, overflow, count);
    end
    rst = 1'b0;
    run_measure(16'd60, -5, b, r, d);
    checks++;
    if (d != 65 || count !== 32'(10 * EDGE_MUL)) begin
      errors++;
      $display("FAIL after_reset_measure: got done_at=%0d count=%0d, want 65 %0d",
               d, count, 10 * EDGE_MUL);
    end
  endtask

  task automatic test_hold_and_retrigger();
    int d;
    // start_i is still high from the previous measurement.
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 32'(10 * EDGE_MUL)) begin
      errors++;
      $display("FAIL hold_no_retrigger: got done=%0b busy=%0b count=%0d, want 1 0 %0d",
               done, busy, count, 10 * EDGE_MUL);
    end
    start = 1'b0;
    window = 16'd30;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || ring_en !== 1'b1) begin
      errors++;
      $display("FAIL retrigger_edge: got done=%0b busy=%0b en=%0b, want 0 1 1", done, busy, ring_en);
    end
    d = 0;
    for (int n = 2; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done) begin
        d = n;
        break;
      end
    end
    $display("txn retrigger window=30 done_at=%0d count=%0d ovf=%0b", d, count, overflow);
    checks++;
    if (d != 35 || count !== 32'(5 * EDGE_MUL)) begin
      errors++;
      $display("FAIL retrigger_result: got done_at=%0d count=%0d, want 35 %0d", d, count, 5 * EDGE_MUL);
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_zero_window();
    test_saturation();
    test_restart_ignored();
    test_reset_mid_count();
    test_hold_and_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_ring_counter.md
Name: adder_ring_counter

Overview:
- Measurement controller for the instrumented adder ring oscillator; sits inside wrapped_project between the LA/IO pins and the adder ring.
- Firmware drives start and window length over la1_data_in.
- The block enables the ring, waits for it to settle, then counts ring edges over a programmed number of wb_clk_i cycles.
- It returns the count on la1_data_out/io_out through the wrapper's tristated outputs.

Parameters:
COUNT_W, 32, width of edge counter / result
WINDOW_W, 16, width of measurement window length (clock cycles)
SETTLE_CYCLES, 4, cycles ring runs before counting starts (>=1)

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
start_i  input  1  level from LA; rising edge starts a measurement
window_i  input  WINDOW_W  window length in cycles, latched at start
ring_osc_i  input  1  asynchronous ring oscillator tap
ring_en_o  output  1  enables ring oscillator
busy_o  output  1  measurement in progress
done_o  output  1  result valid, held until next start
overflow_o  output  1  counter saturated during last measurement
count_o  output  COUNT_W  edge count of last measurement

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i.
- Reset values: all outputs 0; state IDLE; start_q 0.
- Reset mid-measurement: returns to IDLE next edge, ring_en_o drops, count cleared.
- Start detection: start_q registers start_i; start_pulse = start_i & ~start_q.
- Edge detection: ring_osc_i passes a 2-FF synchronizer, then a registered edge detector.
  - edge = sync & ~sync_d, i.e. rising edges only.
  - Valid for ring frequency < wb_clk_i/2; higher frequencies alias. Firmware selects adder taps accordingly.
- FSM: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - On start_pulse: latch window_i into win_r, clear count/overflow, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - ring_en_o=1, busy_o=1, done_o=0; edges ignored.
  - Decrement the settle counter; at 0:
    - if win_r==0, go to DONE (count 0);
    - else load window counter with win_r-1 and go to COUNT.
- COUNT:
  - ring_en_o=1, busy_o=1.
  - Each cycle an edge is seen, count += 1.
  - At COUNT_W max the count saturates, overflow_o=1, no wrap.
  - At window counter 0 (after exactly win_r cycles in COUNT) go to DONE.
  - An edge on the final COUNT cycle is counted.
- DONE:
  - ring_en_o=0, busy_o=0, done_o=1; count_o/overflow_o held.
  - On start_pulse, behave as from IDLE (latch, clear, go to SETTLE); done_o drops the same edge.
- start_pulse while in SETTLE or COUNT is ignored. window_i changes mid-measurement have no effect.
- count_o is a register, updated in COUNT only.
- Latency:
  - ring_en_o rises 1 cycle after start_i rises.
  - done_o rises SETTLE_CYCLES + win_r + 1 cycles after the start_pulse cycle.
- Counting window is defined at the edge-detector output. Synchronizer delay shifts the window by 3 cycles relative to the pin; this is accepted.

Optional Feature:
- Macro: ADDER_RING_BOTH_EDGES_EN.
- Defined: edge = sync ^ sync_d. Both ring transitions are counted, doubling resolution; saturation rules unchanged.
- Undefined: rising edges only, as above.

Decomposition:
- Package adder_ring_pkg: state enum (IDLE, SETTLE, COUNT, DONE), default width constants.
- Sub-module ring_edge_sync: 2-FF synchronizer + edge detector, honours the macro, output registered.
- FSM and counters stay in adder_ring_counter.

Test Plan:
- Ring toggles every 3 clocks (period 6), window_i=60, start rising -> busy_o for 4+60 cycles, then done_o=1, count_o=10, overflow_o=0, ring_en_o=0.
- Same stimulus with ADDER_RING_BOTH_EDGES_EN -> count_o=20.
- window_i=0 -> done_o rises 5 cycles after start, count_o=0, ring_en_o high exactly 4 cycles.
- COUNT_W=4, ring period 2 clocks, window_i=100 -> count_o=15, overflow_o=1.
- Second start_i rising edge during COUNT -> ignored, result equals single-run value. wb_rst_i asserted mid-COUNT -> next cycle all outputs 0, state IDLE. New start afterwards measures correctly.
- start_i held high after DONE -> no retrigger. Drop and re-raise -> done_o clears same cycle busy_o rises, new count replaces old.
